invsqrt_nr_ctrl: RTL and testbench

- Sequencer that computes y = 1/sqrt(x) using the fast inverse square root method.
- Seeds y0 from a magic-constant bit trick, then runs N_ITER Newton-Raphson steps: y <- y*(1.5 - 0.5*x*y*y).
- Time-shares one external fp_mul_pipe instance and one external pipelined fp_sub; the controller itself holds no FP arithmetic.
- Sits between the stream source and the shared arithmetic units; all values are 31-bit positive single precision (sign bit implied 0).

---
 rtl/invsqrt_pkg.sv | 26 ++
 rtl/invsqrt_seed.sv | 29 ++
 rtl/invsqrt_nr_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_invsqrt_nr_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/invsqrt_pkg.sv
// Shared types and constants for the fast inverse square root sequencer.
package invsqrt_pkg;

  typedef struct packed {
    logic [7:0]  exp;
    logic [22:0] man;
  } fp31_t;

  localparam logic [30:0] FP_HALF       = 31'h3F000000;
  localparam logic [30:0] FP_THREEHALF  = 31'h3FC00000;
  localparam logic [30:0] FP_INF        = 31'h7F800000;
  localparam logic [30:0] FP_QNAN       = 31'h7FC00000;
  localparam logic [30:0] MAGIC_DEFAULT = 31'h5F3759DF;

  typedef enum logic [2:0] {
    StIdle,
    StSeed,
    StMulXh,
    StMulYy,
    StMulXt,
    StSub,
    StMulY,
    StDone
  } state_e;

endpackage

// File: rtl/invsqrt_seed.sv
// Classifies x and produces either the special-case result or the magic-constant seed y0.
module invsqrt_seed
  import invsqrt_pkg::*;
#(
  parameter logic [30:0] MAGIC = MAGIC_DEFAULT
) (
  input  logic [30:0] x_i,
  output logic [30:0] y_o,
  output logic        special_o
);

  fp31_t x;
  assign x = fp31_t'(x_i);

  always_comb begin
    special_o = 1'b1;
    y_o       = '0;
    if (x.exp == 8'h00) begin
      // Zero and denormals are flushed to zero, so the result is +inf.
      y_o = FP_INF;
    end else if (x.exp == 8'hFF) begin
      y_o = (x.man == '0) ? '0 : FP_QNAN;
    end else begin
      special_o = 1'b0;
      y_o       = MAGIC - (x_i >> 1);
    end
  end

endmodule

// File: rtl/invsqrt_nr_ctrl.sv
// Sequences 1/sqrt(x) through a shared external multiplier and subtractor:
// magic seed followed by N_ITER Newton-Raphson refinements.
module invsqrt_nr_ctrl
  import invsqrt_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned SUB_LAT = 2,
  parameter int unsigned N_ITER  = 2,
  parameter logic [30:0] MAGIC   = MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [30:0] in_x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [30:0] out_y,
  output logic        out_special,
  output logic        mul_ce,
  output logic [30:0] mul_a,
  output logic [30:0] mul_b,
  input  logic [30:0] mul_y,
  output logic        sub_ce,
  output logic [30:0] sub_a,
  output logic [30:0] sub_b,
  input  logic [30:0] sub_y
);

  localparam logic [7:0] MulCnt   = 8'(MUL_LAT);
  localparam logic [7:0] SubCnt   = 8'(SUB_LAT);
  localparam logic [1:0] LastIter = 2'(N_ITER - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  iter_q, iter_d;
  logic [30:0] x_q, x_d, xh_q, xh_d, y_q, y_d, t_q, t_d;
  logic        in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [30:0] out_y_q, out_y_d;
  logic        out_special_q, out_special_d;
  logic        mul_ce_q, mul_ce_d, sub_ce_q, sub_ce_d;
  logic [30:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, sub_a_q, sub_a_d, sub_b_q, sub_b_d;

  logic [30:0] seed_y;
  logic        seed_special;
  logic        last;

  invsqrt_seed #(
    .MAGIC(MAGIC)
  ) u_seed (
    .x_i      (x_q),
    .y_o      (seed_y),
    .special_o(seed_special)
  );

  assign last = (cnt_q == 8'd0);

  always_comb begin
    state_d       = state_q;
    cnt_d         = last ? cnt_q : cnt_q - 8'd1;
    iter_d        = iter_q;
    x_d           = x_q;
    xh_d          = xh_q;
    y_d           = y_q;
    t_d           = t_q;
    out_valid_d   = out_valid_q;
    out_y_d       = out_y_q;
    out_special_d = out_special_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    sub_a_d       = sub_a_q;
    sub_b_d       = sub_b_q;

    // Operand outputs are registered, so each state's operands are loaded on its entry edge,
    // taking freshly captured results straight from the unit outputs.
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          x_d           = in_x;
          out_special_d = 1'b0;
          state_d       = StSeed;
        end
      end
      StSeed: begin
        y_d    = seed_y;
        iter_d = 2'd0;
        if (seed_special) begin
          out_special_d = 1'b1;
          state_d       = StDone;
        end else begin
          state_d = StMulXh;
          cnt_d   = MulCnt;
          mul_a_d = x_q;
          mul_b_d = FP_HALF;
        end
      end
      StMulXh: begin
        if (last) begin
          xh_d    = mul_y;
          state_d = StMulYy;
          cnt_d   = MulCnt;
          mul_a_d = y_q;
          mul_b_d = y_q;
        end
      end
      StMulYy: begin
        if (last) begin
          t_d     = mul_y;
          state_d = StMulXt;
          cnt_d   = MulCnt;
          mul_a_d = xh_q;
          mul_b_d = mul_y;
        end
      end
      StMulXt: begin
        if (last) begin
          t_d     = mul_y;
          state_d = StSub;
          cnt_d   = SubCnt;
          sub_a_d = FP_THREEHALF;
          sub_b_d = mul_y;
        end
      end
      StSub: begin
        if (last) begin
          t_d     = sub_y;
          state_d = StMulY;
          cnt_d   = MulCnt;
          mul_a_d = y_q;
          mul_b_d = sub_y;
        end
      end
      StMulY: begin
        if (last) begin
          y_d    = mul_y;
          iter_d = iter_q + 2'd1;
          if (iter_q == LastIter) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            out_y_d     = mul_y;
          end else begin
            state_d = StMulYy;
            cnt_d   = MulCnt;
            mul_a_d = mul_y;
            mul_b_d = mul_y;
          end
        end
      end
      StDone: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end else if (!out_valid_q) begin
          // Special-case results reach DONE before out_y is loaded, so present them a cycle later.
          out_valid_d = 1'b1;
          out_y_d     = y_q;
        end
      end
      default: state_d = StIdle;
    endcase

    in_ready_d = (state_d == StIdle);
    mul_ce_d   = (state_d == StMulXh) || (state_d == StMulYy) || (state_d == StMulXt) ||
                 (state_d == StSub)   || (state_d == StMulY);
    sub_ce_d   = (state_d == StSub);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      iter_q        <= '0;
      x_q           <= '0;
      xh_q          <= '0;
      y_q           <= '0;
      t_q           <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_y_q       <= '0;
      out_special_q <= 1'b0;
      mul_ce_q      <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      sub_ce_q      <= 1'b0;
      sub_a_q       <= '0;
      sub_b_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      iter_q        <= iter_d;
      x_q           <= x_d;
      xh_q          <= xh_d;
      y_q           <= y_d;
      t_q           <= t_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_y_q       <= out_y_d;
      out_special_q <= out_special_d;
      mul_ce_q      <= mul_ce_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      sub_ce_q      <= sub_ce_d;
      sub_a_q       <= sub_a_d;
      sub_b_q       <= sub_b_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_y       = out_y_q;
  assign out_special = out_special_q;
  assign mul_ce      = mul_ce_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign sub_ce      = sub_ce_q;
  assign sub_a       = sub_a_q;
  assign sub_b       = sub_b_q;

endmodule

// File: tb/tb_invsqrt_nr_ctrl.sv
// Directed bench for invsqrt_nr_ctrl with behavioural pipelined FP multiplier and subtractor.
module tb_invsqrt_nr_ctrl;

  localparam int MUL_LAT  = 3;
  localparam int SUB_LAT  = 2;
  localparam int NORM_LAT = 35;
  localparam int SPEC_LAT = 2;
  localparam logic [30:0] C_MAGIC = 31'h5F3759DF;
  localparam logic [30:0] C_HALF  = 31'h3F000000;
  localparam logic [30:0] C_1P5   = 31'h3FC00000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [30:0] in_x = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [30:0] out_y;
  logic        out_special;
  logic        mul_ce, sub_ce;
  logic [30:0] mul_a, mul_b, mul_y, sub_a, sub_b, sub_y;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  invsqrt_nr_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_special(out_special),
    .mul_ce     (mul_ce),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_y      (mul_y),
    .sub_ce     (sub_ce),
    .sub_a      (sub_a),
    .sub_b      (sub_b),
    .sub_y      (sub_y)
  );

  function automatic real f2r(input logic [30:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {1'b0, 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [30:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [24:0] m;
    if (r <= 0.0) return '0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    m = {2'b01, d[51:29]} + 25'(d[28]);
    if (m[24]) begin
      m = m >> 1;
      e = e + 11'd1;
    end
    return {e[7:0], m[22:0]};
  endfunction

  logic [30:0] mul_pipe [MUL_LAT];
  logic [30:0] sub_pipe [SUB_LAT];

  always @(posedge clk) begin
    if (mul_ce) begin
      mul_pipe[0] <= r2f(f2r(mul_a) * f2r(mul_b));
      for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
    if (sub_ce) begin
      sub_pipe[0] <= r2f(f2r(sub_a) - f2r(sub_b));
      for (int i = 1; i < SUB_LAT; i++) sub_pipe[i] <= sub_pipe[i-1];
    end
  end

  assign mul_y = mul_pipe[MUL_LAT-1];
  assign sub_y = sub_pipe[SUB_LAT-1];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [30:0] x);
    in_valid = 1'b1;
    in_x     = x;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    tests_run++;
    if ({in_ready, out_valid, out_special, mul_ce, sub_ce} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {in_ready, out_valid, out_special, mul_ce, sub_ce});
    end
    tests_run++;
    if ({out_y, mul_a, mul_b, sub_a, sub_b} !== '0) begin
      tests_failed++;
      $display("FAIL reset_buses: got y=%h ma=%h mb=%h sa=%h sb=%h required all 0",
               out_y, mul_a, mul_b, sub_a, sub_b);
    end
    tick();
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    tests_run++;
    if ({in_ready, out_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL reset_release: got rdy/vld=%b required 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_normal(input logic [30:0] x);
    logic [30:0] y0, xh;
    int lat, sub_cnt, sub_run, sub_max, mce_cnt;
    real exact, got, err;
    y0 = C_MAGIC - (x >> 1);
    xh = x - 31'h00800000;
    lat = -1; sub_cnt = 0; sub_run = 0; sub_max = 0; mce_cnt = 0;
    out_ready = 1'b1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL norm_ready x=%h: got %b required 1", x, in_ready);
    end
    accept(x);
    tests_run++;
    if ({in_ready, mul_ce} !== 2'b00) begin
      tests_failed++;
      $display("FAIL norm_seed x=%h: got rdy/mce=%b required 00", x, {in_ready, mul_ce});
    end
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (mul_ce) mce_cnt++;
      if (sub_ce) begin
        sub_cnt++;
        sub_run++;
        if (sub_run > sub_max) sub_max = sub_run;
      end else begin
        sub_run = 0;
      end
      if (k == 1) begin
        tests_run++;
        if ({mul_a, mul_b} !== {x, C_HALF}) begin
          tests_failed++;
          $display("FAIL op_xh x=%h: got a=%h b=%h required a=%h b=%h", x, mul_a, mul_b, x, C_HALF);
        end
      end
      if (k == 5) begin
        tests_run++;
        if ({mul_a, mul_b} !== {y0, y0}) begin
          tests_failed++;
          $display("FAIL op_yy x=%h: got a=%h b=%h required %h", x, mul_a, mul_b, y0);
        end
      end
      if (k == 9) begin
        tests_run++;
        if (mul_a !== xh) begin
          tests_failed++;
          $display("FAIL op_xt x=%h: got a=%h required %h", x, mul_a, xh);
        end
      end
      if (k == 13) begin
        tests_run++;
        if ({sub_ce, sub_a} !== {1'b1, C_1P5}) begin
          tests_failed++;
          $display("FAIL op_sub x=%h: got ce=%b a=%h required ce=1 a=%h", x, sub_ce, sub_a, C_1P5);
        end
      end
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    tests_run++;
    if (lat !== NORM_LAT) begin
      tests_failed++;
      $display("FAIL norm_latency x=%h: got %0d required %0d", x, lat, NORM_LAT);
    end
    tests_run++;
    if (mce_cnt !== NORM_LAT - 1) begin
      tests_failed++;
      $display("FAIL mul_ce_cycles x=%h: got %0d required %0d", x, mce_cnt, NORM_LAT - 1);
    end
    tests_run++;
    if ({sub_cnt, sub_max} !== {32'(2 * (SUB_LAT + 1)), 32'(SUB_LAT + 1)}) begin
      tests_failed++;
      $display("FAIL sub_ce_pulses x=%h: got total=%0d run=%0d required %0d/%0d",
               x, sub_cnt, sub_max, 2 * (SUB_LAT + 1), SUB_LAT + 1);
    end
    tests_run++;
    if (out_special !== 1'b0) begin
      tests_failed++;
      $display("FAIL norm_special x=%h: got %b required 0", x, out_special);
    end
    exact = 1.0 / $sqrt(f2r(x));
    got   = f2r(out_y);
    err   = (got > exact) ? (got - exact) / exact : (exact - got) / exact;
    tests_run++;
    if (err > 1.0e-5) begin
      tests_failed++;
      $display("FAIL norm_accuracy x=%h: got y=%h relerr=%e required relerr<=1e-5", x, out_y, err);
    end
    tick();
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL norm_handshake x=%h: got vld/rdy=%b required 01", x, {out_valid, in_ready});
    end
  endtask

  task automatic test_special(input logic [30:0] x, input logic [30:0] exp_y);
    int lat, mce_cnt;
    lat = -1; mce_cnt = 0;
    out_ready = 1'b1;
    accept(x);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (mul_ce) mce_cnt++;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    tests_run++;
    if (lat !== SPEC_LAT) begin
      tests_failed++;
      $display("FAIL spec_latency x=%h: got %0d required %0d", x, lat, SPEC_LAT);
    end
    tests_run++;
    if ({out_special, out_y} !== {1'b1, exp_y}) begin
      tests_failed++;
      $display("FAIL spec_result x=%h: got sp=%b y=%h required sp=1 y=%h", x, out_special, out_y,
               exp_y);
    end
    tests_run++;
    if (mce_cnt !== 0) begin
      tests_failed++;
      $display("FAIL spec_mul_ce x=%h: got %0d active cycles required 0", x, mce_cnt);
    end
    tick();
  endtask

  task automatic test_backpressure;
    logic [30:0] held;
    int lat;
    lat = -1;
    out_ready = 1'b0;
    accept(31'h42500000);
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    tests_run++;
    if (lat !== NORM_LAT) begin
      tests_failed++;
      $display("FAIL bp_latency: got %0d required %0d", lat, NORM_LAT);
    end
    held     = out_y;
    in_valid = 1'b1;
    in_x     = 31'h3E800000;
    for (int k = 0; k < 10; k++) begin
      tick();
      tests_run++;
      if ({out_valid, in_ready, out_y} !== {2'b10, held}) begin
        tests_failed++;
        $display("FAIL bp_hold cycle %0d: got vld=%b rdy=%b y=%h required 1 0 %h",
                 k, out_valid, in_ready, out_y, held);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL bp_release: got vld/rdy=%b required 01", {out_valid, in_ready});
    end
    tick();
    tests_run++;
    if ({out_valid, in_ready, mul_ce} !== 3'b010) begin
      tests_failed++;
      $display("FAIL bp_idle: got vld/rdy/mce=%b required 010", {out_valid, in_ready, mul_ce});
    end
  endtask

  task automatic test_reset_mid_op;
    out_ready = 1'b1;
    accept(31'h40800000);
    for (int k = 0; k < 12; k++) tick();
    rst = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, in_ready, mul_ce, sub_ce, mul_a, mul_b, out_y} !== '0) begin
      tests_failed++;
      $display("FAIL midop_reset: got vld=%b rdy=%b mce=%b sce=%b a=%h b=%h y=%h required all 0",
               out_valid, in_ready, mul_ce, sub_ce, mul_a, mul_b, out_y);
    end
    tick();
    tests_run++;
    if ({out_valid, mul_ce} !== 2'b00) begin
      tests_failed++;
      $display("FAIL midop_held: got vld/mce=%b required 00", {out_valid, mul_ce});
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    test_normal(31'h3E800000);
  endtask

  initial begin
    test_reset();
    test_normal(31'h40800000);
    test_normal(31'h3E800000);
    test_normal(31'h42500000);
    test_special(31'h00000000, 31'h7F800000);
    test_special(31'h7F800000, 31'h00000000);
    test_special(31'h7FC00001, 31'h7FC00000);
    test_backpressure();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
